pipeline_skid_stage: RTL and testbench

//  Parametrised successor of the single-overflow pipeline stage. It provides
//  an N-entry elastic buffer with stall backpressure and flush-by-ID.

---
 rtl/pipeline_skid_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_pipeline_skid_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_stage.sv
// -----------------------------------------------------------------------------
// pipeline_skid_stage
//
// Elastic pipeline stage with an N-entry circular buffer. It replaces the older
// stage that had a single overflow slot. Each accepted beat gets stage_offset
// added to its address. The stage forwards ID, valid and flush information, so
// stages can be chained on the address/ID pipeline.
//
// Backpressure:
//   - out_stall is asserted only while the buffer is full.
//   - out_stall is derived from registered state alone. There is no
//     combinational path from in_stall to out_stall.
//
// Flush-by-ID:
//   - When in_flush is high, every stored valid entry whose ID equals
//     in_flush_id is turned into a hole.
//   - A hole head is dropped in the cycle after it reaches the head, whether
//     or not in_stall is high.
//
// Handshake (valid/ready semantics):
//   - Upstream: a beat is taken at a rising edge when in_valid && !out_stall.
//     While out_stall is high, upstream holds its beat.
//   - Downstream: the head beat is taken at a rising edge when
//     out_valid && !in_stall.
//
// Optional feature:
//   - Macro PIPE_STAGE_STATS_EN adds two saturating statistics counters:
//     stat_stall_cycles and stat_flushed.
//
// Parameters:
//   ADDR_W  address width (address arithmetic wraps mod 2^ADDR_W)
//   ID_W    transaction ID width
//   DEPTH   buffer entries, power of 2, >= 2
//   CNT_W   statistics counter width
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   stage_offset               added to in_address on acceptance
//   in_address/in_id/in_valid  upstream beat
//   out_stall                  buffer full, upstream must hold
//   in_flush/in_flush_id       flush request and the ID to flush
//   out_address/out_id/out_valid  head entry (address/ID are 0 when not valid)
//   out_flush/out_flush_id     flush request delayed one cycle
//   in_stall                   downstream stall
//   out_count                  occupied slots, holes included
//   stat_stall_cycles, stat_flushed  (PIPE_STAGE_STATS_EN only)
// -----------------------------------------------------------------------------
module pipeline_skid_stage #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          stage_offset,
  input  logic [ADDR_W-1:0]          in_address,
  input  logic [ID_W-1:0]            in_id,
  input  logic                       in_valid,
  output logic                       out_stall,
  input  logic                       in_flush,
  input  logic [ID_W-1:0]            in_flush_id,
  output logic [ADDR_W-1:0]          out_address,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_valid,
  output logic                       out_flush,
  output logic [ID_W-1:0]            out_flush_id,
  input  logic                       in_stall,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0]           stat_stall_cycles,
  output logic [CNT_W-1:0]           stat_flushed,
`endif
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH+1);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [ID_W-1:0]     id_q   [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [CNT_BITS-1:0] count_q;

  logic                full;
  logic                empty;
  logic                head_vld;
  logic                accept;
  logic                pop_valid;
  logic                pop_hole;
  logic                pop;
  logic                in_hit;
  logic [DEPTH-1:0]    flush_hit;
  logic [ADDR_W-1:0]   new_addr;

  // ---------------------------------------------------------------------------
  // Handshake and pop decisions
  // ---------------------------------------------------------------------------
  assign full      = (count_q == CNT_BITS'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_vld  = vld_q[head_q];
  assign accept    = in_valid && !full;

  // A valid head leaves only when downstream takes it. A hole head is dropped
  // unconditionally, so holes never block the stage behind a stall.
  assign pop_valid = !empty && head_vld && !in_stall;
  assign pop_hole  = !empty && !head_vld;
  assign pop       = pop_valid || pop_hole;

  assign new_addr  = in_address + stage_offset;

  // ---------------------------------------------------------------------------
  // Flush matching
  // ---------------------------------------------------------------------------
  // Slots that are not occupied always carry vld=0, because a pop clears the
  // bit. So matching on vld alone is enough to find occupied entries.
  always_comb begin
    flush_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_hit[i] = in_flush && vld_q[i] && (id_q[i] == in_flush_id);
    end
  end

  // An incoming beat that matches the flush is consumed but stored as a hole.
  assign in_hit = accept && in_flush && (in_id == in_flush_id);

  // ---------------------------------------------------------------------------
  // Buffer state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      // Flush first.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_hit[i]) vld_q[i] <= 1'b0;
      end

      // Pop clears the head slot. This may override a flush of the same slot,
      // which is harmless: a valid head popped now counts as delivered.
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end

      // The tail slot is free whenever accept is true, so this write never
      // collides with the flush or pop updates above.
      if (accept) begin
        addr_q[tail_q] <= new_addr;
        id_q[tail_q]   <= in_id;
        vld_q[tail_q]  <= !in_hit;
        tail_q         <= tail_q + PTR_W'(1);
      end

      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Flush forwarding
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_flush    <= 1'b0;
      out_flush_id <= '0;
    end else begin
      out_flush    <= in_flush;
      out_flush_id <= in_flush_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid   = !empty && head_vld;
  assign out_address = out_valid ? addr_q[head_q] : '0;
  assign out_id      = out_valid ? id_q[head_q]   : '0;
  assign out_stall   = full;
  assign out_count   = count_q;

`ifdef PIPE_STAGE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (saturating)
  // ---------------------------------------------------------------------------
  logic [CNT_BITS:0] flushed_now;
  logic [CNT_W:0]    stall_sum;
  logic [CNT_W:0]    flush_sum;

  // Count the entries invalidated this cycle. A valid head that is delivered
  // in the flush cycle is excluded from the count.
  always_comb begin
    flushed_now = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_hit[i] && !(pop_valid && (head_q == PTR_W'(i)))) begin
        flushed_now = flushed_now + (CNT_BITS+1)'(1);
      end
    end
    if (in_hit) flushed_now = flushed_now + (CNT_BITS+1)'(1);
  end

  assign stall_sum = {1'b0, stat_stall_cycles} + (CNT_W+1)'(1);
  assign flush_sum = {1'b0, stat_flushed} + (CNT_W+1)'(flushed_now);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_flushed      <= '0;
    end else begin
      if (out_valid && in_stall) begin
        stat_stall_cycles <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
      end
      stat_flushed <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipeline_skid_stage
//
// Self-checking bench for pipeline_skid_stage (ADDR_W=8, ID_W=4, DEPTH=4).
// The reference model is a queue of {addr, id, vld} entries:
//   - Accepted beats are pushed at the back.
//   - The front is popped when delivered, or when it is a hole.
//   - A flush clears vld on matching entries.
// Each step drives inputs on the falling edge. It then updates the model at the
// rising edge and compares the outputs on the next falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_skid_stage;

  localparam int ADDR_W = 8;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int EW     = ADDR_W + ID_W + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] stage_offset;
  logic [ADDR_W-1:0] in_address;
  logic [ID_W-1:0]   in_id;
  logic              in_valid;
  logic              out_stall;
  logic              in_flush;
  logic [ID_W-1:0]   in_flush_id;
  logic [ADDR_W-1:0] out_address;
  logic [ID_W-1:0]   out_id;
  logic              out_valid;
  logic              out_flush;
  logic [ID_W-1:0]   out_flush_id;
  logic              in_stall;
  logic [$clog2(DEPTH+1)-1:0] out_count;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stat_stall_cycles;
  logic [CNT_W-1:0]  stat_flushed;
`endif

  pipeline_skid_stage #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stage_offset(stage_offset),
    .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
    .out_stall(out_stall), .in_flush(in_flush), .in_flush_id(in_flush_id),
    .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
    .out_flush(out_flush), .out_flush_id(out_flush_id), .in_stall(in_stall),
`ifdef PIPE_STAGE_STATS_EN
    .stat_stall_cycles(stat_stall_cycles), .stat_flushed(stat_flushed),
`endif
    .out_count(out_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  // Entry layout: {addr[12:5], id[4:1], vld[0]}
  logic [EW-1:0]   exp_q[$];
  logic            exp_flush;
  logic [ID_W-1:0] exp_flush_id;
  int unsigned     exp_stall_cycles;
  int unsigned     exp_flushed;
  int              n_checks;
  int              n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (exp_q.size() > 0) && exp_q[0][0];
    check("out_valid",    32'(out_valid), 32'(ev));
    check("out_address",  32'(out_address), ev ? 32'(exp_q[0][EW-1:ID_W+1]) : 32'd0);
    check("out_id",       32'(out_id), ev ? 32'(exp_q[0][ID_W:1]) : 32'd0);
    check("out_stall",    32'(out_stall), 32'(exp_q.size() == DEPTH));
    check("out_count",    32'(out_count), 32'(exp_q.size()));
    check("out_flush",    32'(out_flush), 32'(exp_flush));
    check("out_flush_id", 32'(out_flush_id), 32'(exp_flush_id));
`ifdef PIPE_STAGE_STATS_EN
    check("stat_stall_cycles", 32'(stat_stall_cycles), exp_stall_cycles);
    check("stat_flushed",      32'(stat_flushed), exp_flushed);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one cycle of stimulus plus the model update
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                      input logic st, input logic fl, input logic [ID_W-1:0] fid);
    logic            acc, head_ok, pop_v, pop_h, hit;
    logic [EW-1:0]   e;
    logic [ADDR_W-1:0] sum;
    in_valid = v; in_address = a; in_id = id;
    in_stall = st; in_flush = fl; in_flush_id = fid;
    acc     = v && (exp_q.size() < DEPTH);
    head_ok = (exp_q.size() > 0) && exp_q[0][0];
    pop_v   = head_ok && !st;
    pop_h   = (exp_q.size() > 0) && !exp_q[0][0];
    sum     = a + stage_offset;
    @(posedge clk);
    if (head_ok && st && exp_stall_cycles < 32'hFFFF) exp_stall_cycles++;
    if (fl) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (!(i == 0 && pop_v) && exp_q[i][0] && exp_q[i][ID_W:1] == fid) begin
          e = exp_q[i]; e[0] = 1'b0; exp_q[i] = e;
          if (exp_flushed < 32'hFFFF) exp_flushed++;
        end
      end
    end
    if (pop_v || pop_h) void'(exp_q.pop_front());
    if (acc) begin
      hit = fl && (id == fid);
      exp_q.push_back({sum, id, !hit});
      if (hit && exp_flushed < 32'hFFFF) exp_flushed++;
    end
    exp_flush    = fl;
    exp_flush_id = fid;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, st, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0; n_pass = 0;
    exp_flush = 1'b0; exp_flush_id = '0;
    exp_stall_cycles = 0; exp_flushed = 0;
    reset = 1'b1;
    stage_offset = '0; in_address = '0; in_id = '0; in_valid = 1'b0;
    in_flush = 1'b0; in_flush_id = '0; in_stall = 1'b0;
    #3;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back beats with no stall: one beat per cycle and no out_stall.
    stage_offset = 8'h10;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h00 + i), 4'(i), 1'b0, 1'b0, '0);
    idle(2, 1'b0);

    // Stall with 5 offers: 4 are accepted and the buffer reports full.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 4'(i), 1'b1, 1'b0, '0);
    check("full_count", 32'(out_count), 32'd4);
    step(1'b1, 8'h44, 4'd4, 1'b0, 1'b0, '0);
    idle(6, 1'b0);

    // Address wrap: 0xF8 + 0x10 = 0x08.
    step(1'b1, 8'hF8, 4'd7, 1'b0, 1'b0, '0);
    check("wrap_address", 32'(out_address), 32'h08);
    idle(2, 1'b0);

    // IDs 1,2,1 held under stall, then flush ID 1; only ID 2 remains live.
    step(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, '0);
    step(1'b1, 8'h02, 4'd2, 1'b1, 1'b0, '0);
    step(1'b1, 8'h03, 4'd1, 1'b1, 1'b0, '0);
    step(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 4'd1);
    check("flush_delayed", 32'(out_flush), 32'd1);
    idle(4, 1'b0);

    // Flush in the same cycle as accepting a matching beat.
    step(1'b1, 8'h33, 4'd3, 1'b0, 1'b1, 4'd3);
    check("flushed_incoming", 32'(out_valid), 32'd0);
    idle(2, 1'b0);

    // Randomised phases with different valid/stall/flush densities.
    for (int ph = 0; ph < 5; ph++) begin
      int pv, ps, pf;
      pv = 30 + ph * 15;
      ps = 10 + ph * 15;
      pf = 5 + ph * 5;
      stage_offset = 8'($urandom_range(0, 255));
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 99) < pv, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 99) < ps, $urandom_range(0, 99) < pf, 4'($urandom_range(0, 3)));
      end
    end

    // Reset while full must clear outputs without waiting for a clock edge.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 4'd5, 1'b1, 1'b1, 4'd9);
    #2;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_stall", 32'(out_stall), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_flush", 32'(out_flush), 32'd0);
    exp_q.delete();
    exp_flush = 1'b0; exp_flush_id = '0;
    exp_stall_cycles = 0; exp_flushed = 0;
    in_valid = 1'b0; in_flush = 1'b0; in_flush_id = '0; in_stall = 1'b0;
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 4'(i), 1'b0, 1'b0, '0);
    idle(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
